// File: rtl/tdes_key_scheduler.sv
// Triple-DES key scheduler: sequences the three DES stages (EDE / DED),
// presents the stage key and direction to the round-key generator, and
// handshakes with the DES round core via core_start / core_done.
module tdes_key_scheduler #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        key_load,
   input  logic [63:0] key1,
   input  logic [63:0] key2,
   input  logic [63:0] key3,
   input  logic [1:0]  keying_opt,
   input  logic        start,
   input  logic        decrypt,
   input  logic        abort,
   input  logic        core_done,
   output logic [63:0] des_key,
   output logic [1:0]  des_mode,
   output logic        core_start,
   output logic [1:0]  stage,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   localparam logic [1:0] MODE_IDLE   = 2'b11;
   localparam logic [1:0] ERR_NOKEY   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_ABORT   = 2'b11;

   state_t      state_reg;
   logic [63:0] k1_reg;
   logic [63:0] k2_reg;
   logic [63:0] k3_reg;
   logic        key_valid_reg;
   logic        dir_reg;
   logic [7:0]  wait_cnt_reg;
   logic [1:0]  stage_next;

   // Stage key: encrypt walks K1,K2,K3; decrypt walks K3,K2,K1.
   function automatic logic [63:0] pick_key(input logic dir, input logic [1:0] stg,
                                            input logic [63:0] ka, input logic [63:0] kb,
                                            input logic [63:0] kc);
      logic [63:0] k;
      case (stg)
         2'd0:    k = dir ? kc : ka;
         2'd1:    k = kb;
         default: k = dir ? ka : kc;
      endcase
      return k;
   endfunction

   // Stage direction: middle stage is inverted relative to the outer two.
   function automatic logic [1:0] pick_mode(input logic dir, input logic [1:0] stg);
      return {1'b0, dir ^ (stg == 2'd1)};
   endfunction

   assign stage_next = 2'(stage + 2'd1);

   // Main controller: state, key store, stage key/mode and all registered outputs.
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state_reg     <= S_IDLE;
         k1_reg        <= '0;
         k2_reg        <= '0;
         k3_reg        <= '0;
         key_valid_reg <= 1'b0;
         dir_reg       <= 1'b0;
         wait_cnt_reg  <= '0;
         stage         <= 2'd0;
         des_key       <= '0;
         des_mode      <= MODE_IDLE;
         core_start    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         err_code      <= 2'b00;
      end else begin
         core_start <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;

         if (state_reg != S_IDLE && abort) begin
            // Abort outranks core_done and timeout in every busy state.
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            des_mode  <= MODE_IDLE;
            err       <= 1'b1;
            err_code  <= ERR_ABORT;
         end else begin
            case (state_reg)
               S_IDLE: begin
                  if (key_load) begin
                     if (keying_opt == 2'b11) begin
                        key_valid_reg <= 1'b0;
                     end else begin
                        key_valid_reg <= 1'b1;
                        k1_reg        <= key1;
                        k2_reg        <= (keying_opt == 2'b10) ? key1 : key2;
                        k3_reg        <= (keying_opt == 2'b00) ? key3 : key1;
                     end
                  end
                  if (start) begin
                     if (key_valid_reg) begin
                        dir_reg   <= decrypt;
                        stage     <= 2'd0;
                        des_key   <= pick_key(decrypt, 2'd0, k1_reg, k2_reg, k3_reg);
                        des_mode  <= pick_mode(decrypt, 2'd0);
                        busy      <= 1'b1;
                        state_reg <= S_SETUP;
                     end else begin
                        err      <= 1'b1;
                        err_code <= ERR_NOKEY;
                     end
                  end
               end
               S_SETUP: begin
                  core_start <= 1'b1;
                  state_reg  <= S_ISSUE;
               end
               S_ISSUE: begin
                  wait_cnt_reg <= '0;
                  state_reg    <= S_WAIT;
               end
               S_WAIT: begin
                  if (core_done) begin
                     if (stage == 2'd2) begin
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                     end else begin
                        stage     <= stage_next;
                        des_key   <= pick_key(dir_reg, stage_next, k1_reg, k2_reg, k3_reg);
                        des_mode  <= pick_mode(dir_reg, stage_next);
                        state_reg <= S_SETUP;
                     end
                  end else if (wait_cnt_reg == TMO_LAST) begin
                     state_reg <= S_IDLE;
                     busy      <= 1'b0;
                     des_mode  <= MODE_IDLE;
                     err       <= 1'b1;
                     err_code  <= ERR_TIMEOUT;
                  end else begin
                     wait_cnt_reg <= wait_cnt_reg + 8'd1;
                  end
               end
               S_DONE: begin
                  state_reg <= S_IDLE;
                  busy      <= 1'b0;
                  des_mode  <= MODE_IDLE;
               end
               default: begin
                  state_reg <= S_IDLE;
                  busy      <= 1'b0;
                  des_mode  <= MODE_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdes_key_scheduler.sv
// Self-checking bench for tdes_key_scheduler with a key/sequence model.
module tb_tdes_key_scheduler;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        key_load = 1'b0;
   logic [63:0] key1 = '0, key2 = '0, key3 = '0;
   logic [1:0]  keying_opt = 2'b00;
   logic        start = 1'b0, decrypt = 1'b0, abort = 1'b0, core_done = 1'b0;
   logic [63:0] des_key;
   logic [1:0]  des_mode, stage, err_code;
   logic        core_start, busy, done, err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [63:0] mk1 = '0, mk2 = '0, mk3 = '0;
   bit          mvalid = 0;
   logic [1:0]  m_err_code = 2'b00;

   localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] K2 = 64'h23456789ABCDEF01;
   localparam logic [63:0] K3 = 64'h456789ABCDEF0123;

   tdes_key_scheduler #(.TIMEOUT(4)) dut (
      .clk(clk), .n_rst(n_rst), .key_load(key_load),
      .key1(key1), .key2(key2), .key3(key3), .keying_opt(keying_opt),
      .start(start), .decrypt(decrypt), .abort(abort), .core_done(core_done),
      .des_key(des_key), .des_mode(des_mode), .core_start(core_start),
      .stage(stage), .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one key_load cycle in IDLE and update the model.
   task automatic load_keys(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c, input logic [1:0] opt);
      key1 = a; key2 = b; key3 = c; keying_opt = opt; key_load = 1'b1;
      tick();
      key_load = 1'b0;
      if (opt == 2'b11) begin
         mvalid = 0;
      end else begin
         mvalid = 1;
         mk1 = a;
         mk2 = (opt == 2'b10) ? a : b;
         mk3 = (opt == 2'b00) ? c : a;
      end
      $display("load keys opt=%b valid=%0d", opt, mvalid);
   endtask

   // One complete 3DES operation with per-stage core_done delays.
   task automatic run_op(input logic dir, input int d0, input int d1, input int d2,
                         input bit noise, input string name);
      logic [63:0] ek[3];
      logic [1:0]  em[3];
      int          dl[3];
      int          cyc, pulses;
      dl = '{d0, d1, d2};
      if (!dir) begin
         ek = '{mk1, mk2, mk3}; em = '{2'b00, 2'b01, 2'b00};
      end else begin
         ek = '{mk3, mk2, mk1}; em = '{2'b01, 2'b00, 2'b01};
      end
      start = 1'b1; decrypt = dir;
      tick();
      start = 1'b0; decrypt = 1'($urandom);
      cyc = 1; pulses = 0;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (des_key !== ek[s] || des_mode !== em[s] || stage !== 2'(s) || busy !== 1'b1 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL %s setup s%0d: key=%h mode=%b stage=%0d busy=%b cs=%b, expected key=%h mode=%b stage=%0d busy=1 cs=0",
                     name, s, des_key, des_mode, stage, busy, core_start, ek[s], em[s], s);
         end
         if (noise) begin
            core_done = 1'b1; start = 1'b1; key_load = 1'b1;
            key1 = {$urandom, $urandom}; key2 = {$urandom, $urandom}; key3 = {$urandom, $urandom};
            keying_opt = 2'($urandom);
         end
         tick(); cyc++;
         core_done = 1'b0; start = 1'b0; key_load = 1'b0;
         if (core_start === 1'b1) pulses++;
         checks++;
         if (core_start !== 1'b1 || des_key !== ek[s] || des_mode !== em[s]) begin
            errors++;
            $display("FAIL %s issue s%0d: cs=%b key=%h mode=%b, expected cs=1 key=%h mode=%b",
                     name, s, core_start, des_key, des_mode, ek[s], em[s]);
         end
         tick(); cyc++;
         for (int d = 0; d <= dl[s]; d++) begin
            checks++;
            if (core_start !== 1'b0 || busy !== 1'b1 || des_key !== ek[s] || des_mode !== em[s] || err !== 1'b0) begin
               errors++;
               $display("FAIL %s wait s%0d d%0d: cs=%b busy=%b key=%h mode=%b err=%b, expected cs=0 busy=1 key=%h mode=%b err=0",
                        name, s, d, core_start, busy, des_key, des_mode, err, ek[s], em[s]);
            end
            if (d < dl[s]) begin
               tick(); cyc++;
            end
         end
         core_done = 1'b1;
         tick(); cyc++;
         core_done = 1'b0;
      end
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b1 || pulses != 3 || cyc != 10 + d0 + d1 + d2 || err_code !== m_err_code) begin
         errors++;
         $display("FAIL %s done: done=%b err=%b busy=%b pulses=%0d cycle=%0d err_code=%b, expected done=1 err=0 busy=1 pulses=3 cycle=%0d err_code=%b",
                  name, done, err, busy, pulses, cyc, err_code, 10 + d0 + d1 + d2, m_err_code);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || des_mode !== 2'b11) begin
         errors++;
         $display("FAIL %s idle: done=%b busy=%b mode=%b, expected 0 0 11", name, done, busy, des_mode);
      end
      $display("op %s dir=%0d delays=%0d/%0d/%0d cycle=%0d", name, dir, d0, d1, d2, cyc);
   endtask

   // Walk an operation up to the first WAIT cycle of stage tgt.
   task automatic goto_wait(input logic dir, input int tgt);
      start = 1'b1; decrypt = dir;
      tick();
      start = 1'b0;
      for (int s = 0; s < tgt; s++) begin
         tick(); tick();
         core_done = 1'b1; tick(); core_done = 1'b0;
      end
      tick(); tick();
   endtask

   task automatic test_reset();
      #1 n_rst = 1'b1;
      #2;
      checks++;
      if (des_key !== 64'd0 || des_mode !== 2'b11 || core_start !== 1'b0 || stage !== 2'd0 ||
          busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
         errors++;
         $display("FAIL reset: key=%h mode=%b cs=%b stage=%0d busy=%b done=%b err=%b code=%b, expected 0 11 0 0 0 0 0 00",
                  des_key, des_mode, core_start, stage, busy, done, err, err_code);
      end
      tick(); tick();
      n_rst = 1'b0;
      tick();
      $display("reset checked");
   endtask

   task automatic test_no_key();
      start = 1'b1;
      tick();
      start = 1'b0;
      m_err_code = 2'b01;
      checks++;
      if (err !== 1'b1 || err_code !== 2'b01 || busy !== 1'b0 || core_start !== 1'b0) begin
         errors++;
         $display("FAIL no_key: err=%b code=%b busy=%b cs=%b, expected 1 01 0 0", err, err_code, busy, core_start);
      end
      tick();
      checks++;
      if (err !== 1'b0 || err_code !== 2'b01 || busy !== 1'b0 || core_start !== 1'b0) begin
         errors++;
         $display("FAIL no_key_after: err=%b code=%b busy=%b cs=%b, expected 0 01 0 0", err, err_code, busy, core_start);
      end
      $display("no-key start checked");
   endtask

   task automatic test_abort_idle();
      abort = 1'b1; core_done = 1'b1;
      tick(); tick();
      abort = 1'b0; core_done = 1'b0;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_code !== m_err_code) begin
         errors++;
         $display("FAIL abort_idle: err=%b busy=%b done=%b code=%b, expected 0 0 0 %b", err, busy, done, err_code, m_err_code);
      end
      $display("abort in idle checked");
   endtask

   task automatic test_vector_3key();
      load_keys(K1, K2, K3, 2'b00);
      run_op(1'b0, 0, 0, 0, 1'b0, "enc3");
   endtask

   task automatic test_vector_2key_dec();
      load_keys(K1, K2, K3, 2'b01);
      run_op(1'b1, 0, 0, 0, 1'b0, "dec2");
   endtask

   task automatic test_single_key();
      load_keys({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 2'b10);
      run_op(1'($urandom), 1, 0, 2, 1'b0, "single");
   endtask

   task automatic test_timeout();
      load_keys(K1, K2, K3, 2'b00);
      goto_wait(1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early %0d: err=%b busy=%b, expected 0 1", i, err, busy);
         end
      end
      tick();
      m_err_code = 2'b10;
      checks++;
      if (err !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0 || des_mode !== 2'b11 || done !== 1'b0) begin
         errors++;
         $display("FAIL timeout: err=%b code=%b busy=%b mode=%b done=%b, expected 1 10 0 11 0",
                  err, err_code, busy, des_mode, done);
      end
      tick();
      $display("timeout checked");
   endtask

   task automatic test_abort();
      goto_wait(1'b0, 1);
      abort = 1'b1; core_done = 1'b1;
      tick();
      abort = 1'b0; core_done = 1'b0;
      m_err_code = 2'b11;
      checks++;
      if (err !== 1'b1 || err_code !== 2'b11 || done !== 1'b0 || busy !== 1'b0 || des_mode !== 2'b11) begin
         errors++;
         $display("FAIL abort: err=%b code=%b done=%b busy=%b mode=%b, expected 1 11 0 0 11",
                  err, err_code, done, busy, des_mode);
      end
      tick();
      checks++;
      if (err !== 1'b0 || err_code !== 2'b11 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_after: err=%b code=%b done=%b, expected 0 11 0", err, err_code, done);
      end
      run_op(1'b0, 0, 0, 0, 1'b0, "post_abort");
   endtask

   task automatic test_illegal_opt();
      load_keys(K1, K2, K3, 2'b11);
      start = 1'b1;
      tick();
      start = 1'b0;
      m_err_code = 2'b01;
      checks++;
      if (err !== 1'b1 || err_code !== 2'b01 || busy !== 1'b0) begin
         errors++;
         $display("FAIL illegal_opt: err=%b code=%b busy=%b, expected 1 01 0", err, err_code, busy);
      end
      tick();
      $display("illegal keying option checked");
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         load_keys({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   2'($urandom_range(0, 2)));
         run_op(1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom), "rand");
      end
   endtask

   task automatic test_reset_mid();
      load_keys(K1, K2, K3, 2'b00);
      goto_wait(1'b1, 2);
      #2 n_rst = 1'b1;
      #1;
      mvalid = 0; mk1 = '0; mk2 = '0; mk3 = '0; m_err_code = 2'b00;
      checks++;
      if (des_key !== 64'd0 || des_mode !== 2'b11 || core_start !== 1'b0 || stage !== 2'd0 ||
          busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid: key=%h mode=%b cs=%b stage=%0d busy=%b done=%b err=%b code=%b, expected 0 11 0 0 0 0 0 00",
                  des_key, des_mode, core_start, stage, busy, done, err, err_code);
      end
      tick();
      n_rst = 1'b0;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after %0d: done=%b err=%b busy=%b cs=%b, expected 0 0 0 0",
                     i, done, err, busy, core_start);
         end
         tick();
      end
      $display("mid-operation reset checked");
   endtask

   initial begin
      test_reset();
      test_no_key();
      test_abort_idle();
      test_vector_3key();
      test_vector_2key_dec();
      test_single_key();
      test_timeout();
      test_abort();
      test_illegal_opt();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
